// File: rtl/bin_comp_pkg.sv
// Shared types for the LSB-first serial magnitude comparator.
package bin_comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RES_EQ = 2'd0,
        RES_GT = 2'd1,
        RES_LT = 2'd2
    } res_e;

    // Fold one bit decision into the running result; a differing bit always wins.
    function automatic res_e res_fold(input res_e acc, input logic eq, input logic gt, input logic lt,
                                      input logic flip);
        res_e r;
        r = acc;
        if (!eq) begin
            r = ((gt & ~flip) | (lt & flip)) ? RES_GT : RES_LT;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_comp_1b.sv
// 1-bit comparator cell: per-bit equal / greater / less decision.
module bin_comp_1b (
    input  logic a_bit,
    input  logic b_bit,
    output logic eq_c,
    output logic gt_c,
    output logic lt_c
);

    assign eq_c = ~(a_bit ^ b_bit);
    assign gt_c = a_bit & ~b_bit;
    assign lt_c = ~a_bit & b_bit;

endmodule

// File: rtl/bin_comp_serial.sv
// LSB-first serial magnitude comparator with registered EQ/GT/LT result.
// Define BIN_COMP_SIGNED_EN to treat operands as two's complement (sign bit decision inverted).
module bin_comp_serial
    import bin_comp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic A_EQ_B,
    output logic A_GT_B,
    output logic A_LT_B
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_e           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    res_e             acc, acc_d;
    logic             busy_d, done_d, eq_d, gt_d, lt_d;
    logic             bit_eq_c, bit_gt_c, bit_lt_c;
    logic             last_bit_c, flip_c;

    bin_comp_1b u_cell (
        .a_bit (a_bit),
        .b_bit (b_bit),
        .eq_c  (bit_eq_c),
        .gt_c  (bit_gt_c),
        .lt_c  (bit_lt_c)
    );

    assign last_bit_c = (cnt == LAST_IDX);

`ifdef BIN_COMP_SIGNED_EN
    assign flip_c = last_bit_c;
`else
    assign flip_c = 1'b0;
`endif

    // Next-state, counter, accumulator and next output values
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        acc_d   = acc;
        busy_d  = busy;
        done_d  = 1'b0;
        eq_d    = A_EQ_B;
        gt_d    = A_GT_B;
        lt_d    = A_LT_B;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    acc_d   = RES_EQ;
                    busy_d  = 1'b1;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                end
            end
            RUN: begin
                if (bit_valid) begin
                    acc_d = res_fold(acc, bit_eq_c, bit_gt_c, bit_lt_c, flip_c);
                    if (last_bit_c) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        eq_d    = (acc_d == RES_EQ);
                        gt_d    = (acc_d == RES_GT);
                        lt_d    = (acc_d == RES_LT);
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= RES_EQ;
            busy   <= 1'b0;
            done   <= 1'b0;
            A_EQ_B <= 1'b0;
            A_GT_B <= 1'b0;
            A_LT_B <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            acc    <= acc_d;
            busy   <= busy_d;
            done   <= done_d;
            A_EQ_B <= eq_d;
            A_GT_B <= gt_d;
            A_LT_B <= lt_d;
        end
    end

endmodule

// File: tb/tb_bin_comp_serial.sv
// Randomized self-checking bench for bin_comp_serial against an arithmetic reference model.
module tb_bin_comp_serial;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic bit_valid = 1'b0;
    logic a_bit = 1'b0;
    logic b_bit = 1'b0;
    logic busy, done, A_EQ_B, A_GT_B, A_LT_B;

    int n_checks = 0;
    int n_pass = 0;
    logic [2:0] last_res = 3'b000;

    bin_comp_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .busy      (busy),
        .done      (done),
        .A_EQ_B    (A_EQ_B),
        .A_GT_B    (A_GT_B),
        .A_LT_B    (A_LT_B)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: {eq, gt, lt} straight from integer comparison.
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef BIN_COMP_SIGNED_EN
        return {($signed(a) == $signed(b)), ($signed(a) > $signed(b)), ($signed(a) < $signed(b))};
`else
        return {(a == b), (a > b), (a < b)};
`endif
    endfunction

    task automatic do_compare(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input int stall_at, input int stall_len,
                              input bit rand_stall, input bit poke_start);
        int idx, cyc, pend;
        bit v;
        logic [2:0] exp_res;
        exp_res = model(a, b);
        // start with a garbage bit alongside; that bit must not be taken
        start = 1'b1;
        bit_valid = 1'($urandom);
        a_bit = 1'($urandom);
        b_bit = 1'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check({tag, ".busy_on"}, 32'(busy), 32'd1);
        check({tag, ".res_clr"}, 32'({A_EQ_B, A_GT_B, A_LT_B}), 32'd0);
        idx = 0;
        pend = stall_len;
        while (idx < int'(W)) begin
            v = 1'b1;
            if (idx == stall_at && pend > 0) begin
                v = 1'b0;
                pend--;
            end else if (rand_stall && $urandom_range(0, 3) == 0) begin
                v = 1'b0;
            end
            bit_valid = v;
            a_bit = v ? a[idx] : 1'($urandom);
            b_bit = v ? b[idx] : 1'($urandom);
            start = poke_start && (cyc == 3);
            @(posedge clk); #1;
            cyc++;
            if (v) idx++;
            if (idx < int'(W)) check({tag, ".run"}, 32'({busy, done}), 32'd2);
        end
        bit_valid = 1'b0;
        start = 1'b0;
        check({tag, ".done"}, 32'({busy, done}), 32'd1);
        check({tag, ".result"}, 32'({A_EQ_B, A_GT_B, A_LT_B}), 32'(exp_res));
        // start during DONE is ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".post_done"}, 32'({busy, done}), 32'd0);
        check({tag, ".hold"}, 32'({A_EQ_B, A_GT_B, A_LT_B}), 32'(exp_res));
        last_res = exp_res;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'($urandom);
            a_bit = 1'($urandom);
            b_bit = 1'($urandom);
            @(posedge clk); #1;
            check("idle.flags", 32'({busy, done}), 32'd0);
            check("idle.hold", 32'({A_EQ_B, A_GT_B, A_LT_B}), 32'(last_res));
        end
        bit_valid = 1'b0;
    endtask

    task automatic reset_abort;
        logic [W-1:0] a, b;
        a = W'($urandom);
        b = W'($urandom);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bit_valid = 1'b1;
            a_bit = a[i];
            b_bit = b[i];
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort.async", 32'({busy, done, A_EQ_B, A_GT_B, A_LT_B}), 32'd0);
        @(posedge clk); #1;
        check("abort.held", 32'({busy, done, A_EQ_B, A_GT_B, A_LT_B}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort.no_done", 32'({busy, done}), 32'd0);
        last_res = 3'b000;
    endtask

    initial begin
        #1;
        check("reset", 32'({busy, done, A_EQ_B, A_GT_B, A_LT_B}), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("reset.release", 32'({busy, done, A_EQ_B, A_GT_B, A_LT_B}), 32'd0);

        do_compare("eq5a", 8'h5A, 8'h5A, -1, 0, 1'b0, 1'b0);
        do_compare("s81_7f", 8'h81, 8'h7F, -1, 0, 1'b0, 1'b0);
        do_compare("lt01_02", 8'h01, 8'h02, -1, 0, 1'b0, 1'b0);
        idle_gap(2);
        do_compare("stall33", 8'h33, 8'h32, 5, 3, 1'b0, 1'b0);
        do_compare("poke", 8'hC4, 8'h3B, -1, 0, 1'b0, 1'b1);
        do_compare("sign_eq", 8'h80, 8'h00, -1, 0, 1'b0, 1'b0);
        reset_abort();
        do_compare("eq10", 8'h10, 8'h10, -1, 0, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom_range(0, 4) == 0) ? a : W'($urandom);
            do_compare("rand", a, b, -1, 0, 1'b1, 1'($urandom));
            idle_gap(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bin_comp_serial.md
# bin_comp_serial

LSB-first serial magnitude comparator: accepts two WIDTH-bit operands one bit pair per accepted beat, least-significant bit first, and reports equal / greater / less once the last bit is in. It is the serial, opposite-direction counterpart of the parallel MSB-first compare path, used where operands arrive over a 1-bit link and no parallel register is available. Per-bit decisions come from the existing 1-bit comparator cell. A small FSM and a bit counter wrap around that cell.

## Interface

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  begins a new comparison; honoured only in IDLE.
- bit_valid  input  1  a_bit/b_bit carry a valid bit pair this cycle.
- a_bit  input  1  current bit of operand A, LSB first.
- b_bit  input  1  current bit of operand B, LSB first.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; the result outputs are valid from this cycle on.
- A_EQ_B  output  1  A == B.
- A_GT_B  output  1  A > B.
- A_LT_B  output  1  A < B.

## Operation

- State machine:
  - IDLE: waits for start. start=1 → RUN. On that transition: clear the bit counter, set the internal accumulator to EQ, drive all three result outputs to 0.
  - RUN: each cycle with bit_valid=1 accepts one bit pair and increments the counter.
    - a_bit > b_bit → accumulator = GT.
    - a_bit < b_bit → accumulator = LT.
    - Equal bits → accumulator unchanged.
    - Because bits arrive LSB-first, a later (more significant) differing bit overrides any earlier decision.
    - Accepting bit index WIDTH-1 → DONE.
  - DONE: done=1 for exactly one cycle. Accumulator is copied to A_EQ_B/A_GT_B/A_LT_B, exactly one of them high. → IDLE.
- Results hold until the next accepted start.
- start while in RUN or DONE: ignored, no restart.
- bit_valid while in IDLE or DONE: ignored.
- bit_valid=0 in RUN: stall; counter and accumulator hold indefinitely.
- start and bit_valid high in the same IDLE cycle: the bit is not accepted. The first bit is taken in the cycle after start.
- Counter is $clog2(WIDTH) bits wide and is compared against WIDTH-1. It never wraps past WIDTH-1.

## Timing

- Reset values, asserted asynchronously: state=IDLE, counter=0, accumulator=EQ, busy=0, done=0, A_EQ_B=0, A_GT_B=0, A_LT_B=0.
- busy=1 from the cycle after start is accepted until the final bit is accepted.
- Latency with back-to-back bits: start at cycle 0, bits at cycles 1..WIDTH, done at cycle WIDTH+1.
- start may be re-asserted in the cycle done is high. It is ignored; it is accepted from the following IDLE cycle onward.
- rst mid-operation aborts immediately and returns all outputs to their reset values. No done pulse is produced for the aborted comparison.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration

- BIN_COMP_SIGNED_EN defined: operands are two's complement. The final bit (index WIDTH-1, the sign) uses the inverted decision:
  - a_bit=1, b_bit=0 → LT.
  - a_bit=0, b_bit=1 → GT.
  - Equal sign bits keep the accumulator.
- BIN_COMP_SIGNED_EN undefined: unsigned comparison on every bit, including the final one.

## Structure

- Package bin_comp_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the 2-bit result encoding {RES_EQ, RES_GT, RES_LT}.
- Sub-module bin_comp_1b computes the per-bit EQ/GT/LT from a_bit/b_bit. The top block contains only the FSM, counter, accumulator and output registers.

## Test plan

- WIDTH=8, unsigned, A=0x5A, B=0x5A, bits back-to-back → done at cycle 9, A_EQ_B=1, others 0.
- A=0x81, B=0x7F:
  - unsigned → A_GT_B=1.
  - with BIN_COMP_SIGNED_EN → A_LT_B=1.
- A=0x01, B=0x02 (LSB favours A, bit 1 favours B) → A_LT_B=1, confirming the later bit overrides.
- A=0x33, B=0x32, with bit_valid=0 for 3 cycles after bit 4 → result A_GT_B=1, done at cycle 12, busy held high through the stall.
- start pulsed at cycle 3 mid-RUN → ignored; bit count and result unaffected.
- rst asserted after bit 5 → all outputs 0 immediately. A new start then a full 0x10 vs 0x10 compare → A_EQ_B=1.
